multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM that sequences a shared-ALU multicycle MIPS datapath: fetch, decode, execute, memory, writeback.
//  Drives ALUOp_o into the ALU control decoder (010 R-type funct, 000 add, 001 sub) and all mux/enable strobes.
//  Waits on a single-port memory handshake; aborts to IDLE on memory timeout.
// PARAMETERS
//  TIMEOUT   16  max cycles a memory state waits for mem_ready_i before abort (>=1)
//  TO_W      5   width of timeout counter (must hold TIMEOUT)
//  RET_W     32  width of retired-instruction counter
// PORTS
//  clk_i            in   1      clock, all state on rising edge
//  rst_i            in   1      synchronous, active-high reset
//  run_i            in   1      level; 1 = leave IDLE / keep executing
//  opcode_i         in   6      IR[31:26], valid from DECODE onward
//  zero_i           in   1      ALU zero flag (beq)
//  mem_ready_i      in   1      memory completes the access this cycle
//  ALUOp_o          out  3      to ALU control: 010 R, 000 add, 001 sub
//  alu_src_a_o      out  1      0 = PC, 1 = reg A
//  alu_src_b_o      out  2      00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  pc_write_o       out  1      unconditional PC load
//  pc_write_cond_o  out  1      PC load if zero_i
//  pc_src_o         out  1      0 = ALU result, 1 = ALUOut reg
//  iord_o           out  1      mem address: 0 = PC, 1 = ALUOut
//  mem_read_o       out  1      memory read request
//  mem_write_o      out  1      memory write request
//  ir_write_o       out  1      IR load
//  reg_write_o      out  1      register file write
//  reg_dst_o        out  1      0 = rt, 1 = rd
//  mem_to_reg_o     out  1      0 = ALUOut, 1 = MDR
//  state_o          out  4      current state encoding (debug)
//  illegal_o        out  1      1-cycle pulse on unknown opcode
//  timeout_o        out  1      1-cycle pulse on memory timeout
//  retired_o        out  RET_W  count of completed instructions, wraps
// BEHAVIOUR
//  States (enc): IDLE 0, FETCH 1, DECODE 2, EX_R 3, EX_ADDR 4, EX_BEQ 5, MEM_RD 6, MEM_WR 7, WB_R 8, WB_MEM 9, EX_I 10, WB_I 11.
//  Reset: state IDLE, timeout cnt 0, retired_o 0, every output 0 (ALUOp_o 000). Reset overrides any state, incl. mid-access.
//  Outputs are pure decode of state; ALU/PC/IR strobes gated by mem_ready_i where noted, combinationally.
//  IDLE: outputs 0; run_i=1 -> FETCH.
//  FETCH: mem_read=1, iord=0, src_a=0, src_b=01, ALUOp=000; on mem_ready_i: ir_write=1, pc_write=1, pc_src=0 -> DECODE.
//  DECODE: src_a=0, src_b=11, ALUOp=000 (branch target). opcode 000000->EX_R; 100011/101011->EX_ADDR; 000100->EX_BEQ;
//   anything else: illegal_o pulse, -> FETCH if run_i else IDLE (not retired).
//  EX_R: src_a=1, src_b=00, ALUOp=010 -> WB_R.  WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 -> retire.
//  EX_ADDR: src_a=1, src_b=10, ALUOp=000 -> MEM_RD (lw) / MEM_WR (sw).
//  MEM_RD: mem_read=1, iord=1; on mem_ready_i -> WB_MEM.  WB_MEM: reg_write=1, reg_dst=0, mem_to_reg=1 -> retire.
//  MEM_WR: mem_write=1, iord=1; on mem_ready_i -> retire.
//  EX_BEQ: src_a=1, src_b=00, ALUOp=001, pc_write_cond=1, pc_src=1 -> retire (taken or not).
//  retire: retired_o += 1 (mod 2^RET_W); next FETCH if run_i else IDLE. run_i=0 never aborts an instruction.
//  Timeout: counter clears on entering FETCH/MEM_RD/MEM_WR, +1 each cycle without mem_ready_i;
//   at TIMEOUT wait cycles: timeout_o pulse, -> IDLE, no ir/pc/reg write. mem_ready_i on that same cycle wins (no timeout).
//  Latency (mem_ready_i in 1st cycle): R 4, lw 5, sw 4, beq 3 cycles FETCH-to-FETCH.
// CONFIGURATION
//  MULTICYCLE_CTRL_ADDI_EN defined: opcode 001000 (addi) DECODE->EX_I (src_a=1, src_b=10, ALUOp=000)
//   -> WB_I (reg_write=1, reg_dst=0, mem_to_reg=0) -> retire; 4 cycles.
//  Undefined: 001000 is illegal (illegal_o pulse); states 10/11 unreachable, not synthesised.
// TESTING
//  rst_i=1 2 cycles, run_i=1, mem_ready_i=1 always, R-type 000000 -> states 1,2,3,8; ALUOp 010 in EX_R; retired_o=1.
//  lw 100011 with mem_ready_i delayed 3 cycles in MEM_RD -> MEM_RD held 4 cycles, mem_read_o=1 iord_o=1, then WB_MEM reg_write.
//  beq 000100, zero_i=1 -> EX_BEQ ALUOp 001, pc_write_cond_o=1, pc_src_o=1; 3 cycles FETCH-to-FETCH.
//  opcode 111111 -> illegal_o 1 cycle in DECODE, retired_o unchanged, back to FETCH.
//  mem_ready_i held 0 in FETCH, TIMEOUT=16 -> timeout_o after 16 wait cycles, state_o=0, no ir_write_o.
//  rst_i asserted during MEM_WR -> next cycle state_o=0, mem_write_o=0, retired_o=0; addi with/without _EN per CONFIGURATION.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a shared-ALU multicycle MIPS datapath (fetch/decode/execute/memory/writeback).
// Optional addi support is enabled by defining MULTICYCLE_CTRL_ADDI_EN.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5,
  parameter int RET_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [5:0]       opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic [2:0]       ALUOp_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             pc_src_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic [3:0]       state_o,
  output logic             illegal_o,
  output logic             timeout_o,
  output logic [RET_W-1:0] retired_o
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    EX_R    = 4'd3,
    EX_ADDR = 4'd4,
    EX_BEQ  = 4'd5,
    MEM_RD  = 4'd6,
    MEM_WR  = 4'd7,
    WB_R    = 4'd8,
`ifdef MULTICYCLE_CTRL_ADDI_EN
    WB_MEM  = 4'd9,
    EX_I    = 4'd10,
    WB_I    = 4'd11
`else
    WB_MEM  = 4'd9
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MULTICYCLE_CTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  state_e             state_q, state_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [RET_W-1:0]   retired_q, retired_d;
  logic               mem_wait, to_hit, retire;

  // A memory state is "waiting" whenever it is not being served this cycle.
  assign mem_wait = ((state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR))
                    && !mem_ready_i;
  assign to_hit   = mem_wait && (to_cnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      to_cnt_q  <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    retire          = 1'b0;
    ALUOp_o         = 3'b000;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_src_o        = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    illegal_o       = 1'b0;
    timeout_o       = 1'b0;

    case (state_q)
      IDLE: if (run_i) state_d = FETCH;
      FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = DECODE;
        end else if (to_hit) begin
          timeout_o = 1'b1;
          state_d   = IDLE;
        end
      end
      DECODE: begin
        alu_src_b_o = 2'b11;
        case (opcode_i)
          OP_RTYPE:      state_d = EX_R;
          OP_LW, OP_SW:  state_d = EX_ADDR;
          OP_BEQ:        state_d = EX_BEQ;
`ifdef MULTICYCLE_CTRL_ADDI_EN
          OP_ADDI:       state_d = EX_I;
`endif
          default: begin
            illegal_o = 1'b1;
            state_d   = run_i ? FETCH : IDLE;
          end
        endcase
      end
      EX_R: begin
        alu_src_a_o = 1'b1;
        ALUOp_o     = 3'b010;
        state_d     = WB_R;
      end
      WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
        retire      = 1'b1;
      end
      EX_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = (opcode_i == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) begin
          state_d = WB_MEM;
        end else if (to_hit) begin
          timeout_o = 1'b1;
          state_d   = IDLE;
        end
      end
      WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire       = 1'b1;
      end
      MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) begin
          retire = 1'b1;
        end else if (to_hit) begin
          timeout_o = 1'b1;
          state_d   = IDLE;
        end
      end
      EX_BEQ: begin
        alu_src_a_o     = 1'b1;
        ALUOp_o         = 3'b001;
        pc_write_cond_o = 1'b1;
        pc_src_o        = 1'b1;
        retire          = 1'b1;
      end
`ifdef MULTICYCLE_CTRL_ADDI_EN
      EX_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = WB_I;
      end
      WB_I: begin
        reg_write_o = 1'b1;
        retire      = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    if (retire) state_d = run_i ? FETCH : IDLE;
  end

  // Counter restarts whenever the state changes, so entering any memory state starts from zero.
  always_comb begin
    to_cnt_d = '0;
    if ((state_d == state_q) && mem_wait) to_cnt_d = to_cnt_q + TO_W'(1);
  end

  always_comb begin
    retired_d = retired_q;
    if (retire) retired_d = retired_q + RET_W'(1);
  end

  assign state_o   = state_q;
  assign retired_o = retired_q;

endmodule
